uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter that pairs with the board's 8N1 receive path: 100 MHz `clk`, 9600 baud default.
- Accepts one byte per valid/ready handshake and serialises it on `RsTx`: start bit, 8 data bits LSB first, then stop bit(s).
- Sits between user logic (echo, LED/switch reporters) and the Basys3 USB-UART `RsTx` pin.

Parameters:
- CLKS_PER_BIT, 10417, `clk` cycles per bit (100e6/9600 rounded); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, 100 MHz, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled only on the accept edge.
- tx_valid  input  1  user requests a send of `tx_data`.
- tx_ready  output  1  high only in IDLE; accept = `tx_valid` && `tx_ready` at a rising edge.
- RsTx  output  1  serial line, idle high, registered output (no combinational path from inputs).
- tx_busy  output  1  equals !`tx_ready`; for LED status.

Behaviour:
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE, `RsTx`=1, `tx_ready`=1, `tx_busy`=0.
  - Baud counter, bit index and shift register cleared.
  - Takes effect immediately, including mid-frame. The line returns high at once; no partial completion. The aborted byte is lost.
- States and transitions:
  - IDLE: `RsTx`=1. On accept: latch `tx_data` into the shift register, go to START, drive `RsTx`=0 from that same edge.
  - START: hold `RsTx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `RsTx`=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7 elapses, go to STOP (or PARITY, see Optional Feature).
  - STOP: `RsTx`=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Cleared on accept, so every bit is exactly CLKS_PER_BIT cycles.
  - Width is $clog2(CLKS_PER_BIT); no free-running prescaler.
- Timing, with N = 1+8+STOP_BITS:
  - Accept at edge E0 gives `RsTx` low from E0 through E0+CLKS_PER_BIT.
  - State returns to IDLE at edge E0+N*CLKS_PER_BIT.
  - `tx_ready` rises at that edge. Earliest next accept is the following edge.
  - Back-to-back frame period is N*CLKS_PER_BIT+1 cycles (one idle-high cycle between frames).
- Handshake:
  - `tx_valid` while `tx_ready`=0 is ignored; no queueing.
  - Changes on `tx_data` during a frame do not affect the frame.
  - `tx_valid` held high continuously sends the current `tx_data` once per frame period.
  - No dependency of `tx_ready` on `tx_valid`.
- Simultaneous events: reset overrides everything. An accept in the same cycle that reset is released is not required to be honoured.
- Glitch-free: `RsTx` changes only on bit boundaries and on reset.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - `RsTx` = XOR of the 8 latched data bits (even parity) for CLKS_PER_BIT cycles.
  - N = 1+8+1+STOP_BITS, so the frame is 11 bits for STOP_BITS=1.
- Undefined: no PARITY state, no parity logic; frame is 8N1 / 8N2 as above.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Reset: hold `rst_n`=0 for 5 cycles, release. Expect `RsTx`=1, `tx_ready`=1, `tx_busy`=0, and the line stays high for 100 cycles with `tx_valid`=0.
- Single byte 0xA5, STOP_BITS=1:
  - `RsTx` sampled at bit mid-points (cycle 8+16k after accept) reads 0,1,0,1,0,0,1,0,1,1.
  - `tx_ready` returns high exactly 160 cycles after the accept edge.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high:
  - Second start bit falls 161 cycles after the first.
  - Exactly one idle-high cycle between the frames.
  - `tx_data` changes mid-frame do not alter the first frame.
- STOP_BITS=2, byte 0x3C: stop level held 32 cycles; `tx_ready` high 176 cycles after accept.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x55. `RsTx`=1 immediately and asynchronously (before the next edge), `tx_ready`=1. The next accept of 0x81 produces a clean full frame.
- With UART_TX_PARITY_EN:
  - Byte 0x07 gives parity bit 1; byte 0x03 gives parity bit 0, sampled at cycle 8+16*9.
  - Frame length 176 cycles.
  - Re-run the 0xA5 test with CLKS_PER_BIT=10417: start to stop-end is 114587 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter. It sends a start bit, then 8 data bits LSB first,
// then STOP_BITS stop bits.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, sampled only on the accept edge
//   tx_valid  send request; accept = tx_valid && tx_ready at a rising edge
//   tx_ready  high only while idle
//   RsTx      registered serial line, idle high
//   tx_busy   inverse of tx_ready
//
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       RsTx,
  output logic       tx_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            line_q, line_d;
  logic            tick;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // End of the current bit period.
  assign tick = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    // The baud counter only runs inside a frame and wraps on each bit boundary.
    if (state_q != StIdle) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
    unique case (state_q)
      StIdle: begin
        line_d = 1'b1;
        cnt_d  = '0;
        bit_d  = '0;
        if (tx_valid) begin
          state_d = StStart;
          shift_d = tx_data;
          line_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          bit_d   = '0;
          line_d  = shift_q[0];
        end
      end
      StData: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            line_d  = par_q;
`else
            state_d = StStop;
            line_d  = 1'b1;
`endif
          end else begin
            // The line always carries shift_q[0]. Load the next bit as the register shifts.
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop;
          bit_d   = '0;
          line_d  = 1'b1;
        end
      end
`endif
      StStop: begin
        line_d = 1'b1;
        if (tick) begin
          if (bit_q == StopLast) begin
            state_d = StIdle;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        line_d  = 1'b1;
      end
    endcase
  end

  assign tx_ready = (state_q == StIdle);
  assign tx_busy  = ~tx_ready;
  assign RsTx     = line_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: a self-checking bench for uart_tx with CLKS_PER_BIT=16.
// Instance dut1 uses one stop bit. Instance dut2 uses two stop bits.
// Expected line levels go into a scoreboard queue when a byte is accepted.
// They are popped at each bit mid-point and compared with the line.
module tb_uart_tx;

  localparam int unsigned Cpb = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned Nbase = 10;
`else
  localparam int unsigned Nbase = 9;
`endif
  localparam int unsigned Fr1 = (Nbase + 1) * Cpb;
  localparam int unsigned Fr2 = (Nbase + 2) * Cpb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic       rdy1, rdy2, line1, line2, busy1, busy2;

  int total = 0;
  int bad = 0;
  logic sb[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(Cpb), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v1),
    .tx_ready(rdy1), .RsTx(line1), .tx_busy(busy1)
  );

  uart_tx #(.CLKS_PER_BIT(Cpb), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v2),
    .tx_ready(rdy2), .RsTx(line2), .tx_busy(busy2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic sel_line(input int sel);
    return (sel == 2) ? line2 : line1;
  endfunction

  function automatic logic sel_rdy(input int sel);
    return (sel == 2) ? rdy2 : rdy1;
  endfunction

  task automatic push_frame(input logic [7:0] d, input int stops);
    sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    sb.push_back(^d);
`endif
    for (int s = 0; s < stops; s++) sb.push_back(1'b1);
  endtask

  // Waits (bounded) for ready, then raises valid for one edge. It returns 1ns after the accept edge.
  task automatic send(input int sel, input logic [7:0] d, input bit push);
    int n = 0;
    while (!sel_rdy(sel) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("ready_timeout", sel_rdy(sel), 1'b1);
    tx_data = d;
    if (sel == 2) v2 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    v2 = 1'b0;
    if (push) push_frame(d, sel);
  endtask

  // Starts 1ns after accept edge E0. It samples every bit at E0+8+16k.
  // Then it checks that ready is low at E0+len-1 and high at E0+len.
  task automatic check_frame(input int sel, input string tag, input int nbits, input int len);
    logic exp;
    repeat (Cpb / 2) @(posedge clk);
    #1;
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) begin
        repeat (Cpb) @(posedge clk);
        #1;
      end
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
        exp = sb.pop_front();
        chk($sformatf("%s_bit%0d", tag, k), sel_line(sel), exp);
      end
    end
    repeat (len - 1 - (Cpb / 2 + Cpb * (nbits - 1))) @(posedge clk);
    #1;
    chk({tag, "_ready_early"}, sel_rdy(sel), 1'b0);
    @(posedge clk); #1;
    chk({tag, "_ready_rise"}, sel_rdy(sel), 1'b1);
  endtask

  initial begin
    // Reset behaviour
    repeat (5) @(posedge clk);
    #1;
    chk("rst_line", line1, 1'b1);
    chk("rst_ready", rdy1, 1'b1);
    chk("rst_busy", busy1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk("idle_line1", line1, 1'b1);
      chk("idle_line2", line2, 1'b1);
    end
    chk("idle_ready2", rdy2, 1'b1);
    chk("idle_busy2", busy2, 1'b0);

    // Single byte 0xA5 with one stop bit
    send(1, 8'hA5, 1'b1);
    chk("a5_busy", busy1, 1'b1);
    check_frame(1, "a5", Nbase + 1, Fr1);

    // Parity patterns; in the default build these are plain frames
    send(1, 8'h07, 1'b1);
    check_frame(1, "p07", Nbase + 1, Fr1);
    send(1, 8'h03, 1'b1);
    check_frame(1, "p03", Nbase + 1, Fr1);

    // Back-to-back: valid held high, data changes mid-frame
    tx_data = 8'h00;
    v1 = 1'b1;
    @(posedge clk); #1;
    push_frame(8'h00, 1);
    tx_data = 8'hFF;
    check_frame(1, "b2b0", Nbase + 1, Fr1);
    chk("b2b_idle_gap", line1, 1'b1);
    @(posedge clk); #1;
    chk("b2b_second_start", line1, 1'b0);
    chk("b2b_second_busy", rdy1, 1'b0);
    push_frame(8'hFF, 1);
    v1 = 1'b0;
    check_frame(1, "b2b1", Nbase + 1, Fr1);

    // Two stop bits, 0x3C
    send(2, 8'h3C, 1'b1);
    check_frame(2, "s2", Nbase + 2, Fr2);

    // Asynchronous reset during data bit 3 of 0x55
    send(1, 8'h55, 1'b0);
    repeat (4 * Cpb + Cpb / 2) @(posedge clk);
    #1;
    chk("mid_bit3_low", line1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_line", line1, 1'b1);
    chk("mid_rst_ready", rdy1, 1'b1);
    chk("mid_rst_busy", busy1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_line", line1, 1'b1);
    send(1, 8'h81, 1'b1);
    check_frame(1, "r81", Nbase + 1, Fr1);

    chk("sb_drained", (sb.size() == 0), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
